// File: rtl/dffr_async_load_pkg.sv
// Shared types and helpers for the asynchronous-clear/asynchronous-load register cell.
package dffr_async_load_pkg;

    // Per-bit asynchronous controls: set forces q to 1 and clr forces q to 0.
    typedef struct packed {
        logic set;
        logic clr;
    } async_ctrl_t;

    // arst dominates aload. set and clr are never both high.
    function automatic async_ctrl_t async_ctrl(
        input logic arst,
        input logic aload,
        input logic adata,
        input logic rst_bit
    );
        async_ctrl_t c;
        c.set = arst ? rst_bit  : (aload & adata);
        c.clr = arst ? ~rst_bit : (aload & ~adata);
        return c;
    endfunction

endpackage

// File: rtl/dffr_async_load_bit.sv
// One-bit D cell: asynchronous clear to RESET_VAL, transparent asynchronous load, enabled capture.
module dffr_async_load_bit
    import dffr_async_load_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic arst,
    input  logic aload,
    input  logic adata,
    input  logic d,
    input  logic enable,
    output logic q
);

    async_ctrl_t ctrl;
    logic        async_set;
    logic        async_clr;
    logic        q_d;
    logic        q_q;

    always_comb begin
        ctrl      = async_ctrl(arst, aload, adata, RESET_VAL);
        async_set = ctrl.set;
        async_clr = ctrl.clr;
    end

    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = d;
        end
    end

    // A level change on adata while aload is high raises the opposite control,
    // so q follows adata transparently; a clk edge during either control is discarded.
    always_ff @(posedge clk or posedge async_clr or posedge async_set) begin
        if (async_clr) begin
            q_q <= 1'b0;
        end else if (async_set) begin
            q_q <= 1'b1;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dffr_async_load.sv
// WIDTH-bit register built from independent one-bit cells sharing clk, arst, aload and enable.
module dffr_async_load
    import dffr_async_load_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             aload,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        dffr_async_load_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk    (clk),
            .arst   (arst),
            .aload  (aload),
            .adata  (adata[i]),
            .d      (d[i]),
            .enable (enable),
            .q      (q[i])
        );
    end

endmodule

// File: tb/tb_dffr_async_load.sv
// Self-checking bench for dffr_async_load: 1-bit hand sequences and an 8-bit vector table.
module tb_dffr_async_load;

    typedef struct {
        string      name;
        int         dut;
        logic [7:0] exp;
    } sb_t;

    typedef struct {
        logic       arst;
        logic       aload;
        logic [7:0] adata;
        logic [7:0] d;
        logic       en;
        logic       pulse;
        logic [7:0] exp;
    } vec_t;

    logic       clk1, arst1, aload1, adata1, d1, en1, q1;
    logic       clk8, arst8, aload8, en8;
    logic [7:0] adata8, d8, q8;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    dffr_async_load u_dut1 (
        .clk    (clk1),
        .arst   (arst1),
        .aload  (aload1),
        .adata  (adata1),
        .d      (d1),
        .enable (en1),
        .q      (q1)
    );

    dffr_async_load #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk    (clk8),
        .arst   (arst8),
        .aload  (aload8),
        .adata  (adata8),
        .d      (d8),
        .enable (en8),
        .q      (q8)
    );

    task automatic push(input string name, input int dut, input logic [7:0] exp);
        sb_t e;
        e.name = name;
        e.dut  = dut;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        sb_t        e;
        logic [7:0] act;
        e   = sb_q.pop_front();
        act = (e.dut == 1) ? {7'b0, q1} : q8;
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
    endtask

    // Expect on the 1-bit DUT, sampled 1 ns after the last stimulus change.
    task automatic exp1(input string name, input logic v);
        push(name, 1, {7'b0, v});
        #1;
        pop_check();
    endtask

    task automatic rise1();
        clk1 = 1'b1;
        #5;
    endtask

    task automatic fall1();
        clk1 = 1'b0;
        #5;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk1 = 0; arst1 = 0; aload1 = 0; adata1 = 0; d1 = 0; en1 = 0;
        clk8 = 0; arst8 = 0; aload8 = 0; adata8 = '0; d8 = '0; en8 = 0;
        #5;

        // Reset dominates every other input, including a running clock.
        arst1 = 1; d1 = 1; adata1 = 1; aload1 = 1; en1 = 1;
        exp1("rst_immediate", 1'b0);
        for (int i = 0; i < 3; i++) begin
            rise1();
            fall1();
        end
        exp1("rst_clk_toggle", 1'b0);
        arst1 = 0;
        exp1("rst_release_aload", 1'b1);

        // Capture on rising edge only.
        aload1 = 0;
        exp1("aload_release_hold", 1'b1);
        d1 = 0;
        rise1();
        exp1("capture_0", 1'b0);
        fall1();
        d1 = 1;
        exp1("d_change_low", 1'b0);
        rise1();
        exp1("capture_1", 1'b1);

        // Clock held high and falling edge do not capture.
        d1 = 0;
        exp1("d_change_high", 1'b1);
        fall1();
        exp1("falling_edge", 1'b1);
        rise1();
        exp1("capture_after_fall", 1'b0);

        // Enable gating.
        en1 = 0; d1 = 1;
        for (int i = 0; i < 3; i++) begin
            fall1();
            rise1();
        end
        exp1("enable_off_hold", 1'b0);
        en1 = 1;
        fall1();
        rise1();
        exp1("enable_on_capture", 1'b1);
        fall1();

        // Transparent asynchronous load with static clock.
        aload1 = 1; adata1 = 0;
        exp1("aload_0", 1'b0);
        adata1 = 1;
        exp1("aload_track_1", 1'b1);
        adata1 = 0;
        exp1("aload_track_0", 1'b0);
        aload1 = 0;
        exp1("aload_drop_hold", 1'b0);
        en1 = 1; d1 = 1;
        rise1();
        exp1("capture_after_aload", 1'b1);
        fall1();

        // Simultaneous arst and rising edge: edge is discarded.
        d1 = 1;
        arst1 = 1; clk1 = 1;
        exp1("arst_with_edge", 1'b0);
        #4;
        arst1 = 0;
        exp1("arst_release_hold", 1'b0);
        fall1();

        // Simultaneous aload and rising edge: aload wins.
        d1 = 0; adata1 = 1;
        aload1 = 1; clk1 = 1;
        exp1("aload_with_edge", 1'b1);
        #4;
        aload1 = 0;
        fall1();

        // 8-bit table: arst, aload, adata, d, en, pulse, expected.
        vecs[0] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 8'h3C, 8'hFF, 1'b1, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 8'hC3, 8'hFF, 1'b1, 1'b0, 8'hC3};
        vecs[4] = '{1'b0, 1'b0, 8'hC3, 8'hFF, 1'b1, 1'b0, 8'hC3};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'hFF};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[8] = '{1'b1, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 8'hA5};
        vecs[9] = '{1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C};

        for (int i = 0; i < 10; i++) begin
            arst8  = vecs[i].arst;
            aload8 = vecs[i].aload;
            adata8 = vecs[i].adata;
            d8     = vecs[i].d;
            en8    = vecs[i].en;
            push($sformatf("w8_vec%0d", i), 8, vecs[i].exp);
            #1;
            if (vecs[i].pulse) begin
                clk8 = 1'b1;
                #5;
                clk8 = 1'b0;
                #5;
            end
            pop_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
